// File: rtl/instr_encoder_pkg.sv
// rtl/instr_encoder_pkg.sv - shared 6502 mnemonic/mode enums, encoder states and per-mode instruction length
package instr_encoder_pkg;

    typedef enum logic [5:0] {
        ADC, AND, ASL, BCC, BCS, BEQ, BIT, BMI, BNE, BPL, BRK, BVC, BVS, CLC,
        CLD, CLI, CLV, CMP, CPX, CPY, DEC, DEX, DEY, EOR, INC, INX, INY, JMP,
        JSR, LDA, LDX, LDY, LSR, NOP, ORA, PHA, PHP, PLA, PLP, ROL, ROR, RTI,
        RTS, SBC, SEC, SED, SEI, STA, STX, STY, TAX, TAY, TSX, TXA, TXS, TYA
    } mnem_t;

    typedef enum logic [3:0] {
        MD_IMP, MD_ACC, MD_IMM, MD_ZPG, MD_ZPX, MD_ZPY, MD_ABS,
        MD_ABX, MD_ABY, MD_IND, MD_XIN, MD_INY, MD_REL
    } mode_t;

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_B0, S_B1, S_B2} state_t;

    localparam logic [1:0] LEN_1 = 2'd1;
    localparam logic [1:0] LEN_2 = 2'd2;
    localparam logic [1:0] LEN_3 = 2'd3;

    function automatic logic [1:0] mode_len(input mode_t m);
        case (m)
            MD_IMP, MD_ACC:                 return LEN_1;
            MD_ABS, MD_ABX, MD_ABY, MD_IND: return LEN_3;
            default:                        return LEN_2;
        endcase
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// rtl/instr_encoder_if.sv - instruction input and byte-write channels of the encoder
interface instr_encoder_if;
    import instr_encoder_pkg::*;

    logic        in_valid;
    logic        in_ready;
    mnem_t       in_mnem;
    mode_t       in_mode;
    logic [15:0] in_operand;

    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;

    modport master (
        output in_valid, in_mnem, in_mode, in_operand, wr_ready,
        input  in_ready, wr_valid, wr_addr, wr_data
    );

    modport slave (
        input  in_valid, in_mnem, in_mode, in_operand, wr_ready,
        output in_ready, wr_valid, wr_addr, wr_data
    );
endinterface

// File: rtl/instr_encoder_opcode_map.sv
// rtl/instr_encoder_opcode_map.sv - combinational (mnemonic, mode) -> {legal, opcode, length} table
module instr_encoder_opcode_map
    import instr_encoder_pkg::*;
(
    input  mnem_t      mnem,
    input  mode_t      mode,
    output logic       legal,
    output logic [7:0] opcode,
    output logic [1:0] len
);
    logic [2:0] aaa;
    logic [2:0] bbb;
    logic [1:0] cc;

    // Opcodes with exactly one encoding: branches and implied instructions
    function automatic logic [7:0] fixed_op(input mnem_t m);
        case (m)
            BPL: return 8'h10;
            BMI: return 8'h30;
            BVC: return 8'h50;
            BVS: return 8'h70;
            BCC: return 8'h90;
            BCS: return 8'hB0;
            BNE: return 8'hD0;
            BEQ: return 8'hF0;
            BRK: return 8'h00;
            RTI: return 8'h40;
            RTS: return 8'h60;
            PHP: return 8'h08;
            PLP: return 8'h28;
            PHA: return 8'h48;
            PLA: return 8'h68;
            DEY: return 8'h88;
            TAY: return 8'hA8;
            INY: return 8'hC8;
            INX: return 8'hE8;
            CLC: return 8'h18;
            SEC: return 8'h38;
            CLI: return 8'h58;
            SEI: return 8'h78;
            TYA: return 8'h98;
            CLV: return 8'hB8;
            CLD: return 8'hD8;
            SED: return 8'hF8;
            TXA: return 8'h8A;
            TXS: return 8'h9A;
            TAX: return 8'hAA;
            TSX: return 8'hBA;
            DEX: return 8'hCA;
            NOP: return 8'hEA;
            default: return 8'h00;
        endcase
    endfunction

    assign len = mode_len(mode);

    // The regular instructions follow the aaa_bbb_cc layout of the 6502 opcode matrix
    always_comb begin
        case (mnem)
            AND, ROL, BIT: aaa = 3'd1;
            EOR, LSR:      aaa = 3'd2;
            ADC, ROR:      aaa = 3'd3;
            STA, STX, STY: aaa = 3'd4;
            LDA, LDX, LDY: aaa = 3'd5;
            CMP, DEC, CPY: aaa = 3'd6;
            SBC, INC, CPX: aaa = 3'd7;
            default:       aaa = 3'd0;
        endcase
    end

    always_comb begin
        legal  = 1'b0;
        opcode = 8'h00;
        bbb    = 3'd0;
        cc     = (mnem inside {BIT, STY, LDY, CPY, CPX}) ? 2'b00 : 2'b10;
        case (mnem)
            ORA, AND, EOR, ADC, STA, LDA, CMP, SBC: begin
                legal = 1'b1;
                case (mode)
                    MD_XIN:  bbb = 3'd0;
                    MD_ZPG:  bbb = 3'd1;
                    MD_IMM:  begin bbb = 3'd2; legal = (mnem != STA); end
                    MD_ABS:  bbb = 3'd3;
                    MD_INY:  bbb = 3'd4;
                    MD_ZPX:  bbb = 3'd5;
                    MD_ABY:  bbb = 3'd6;
                    MD_ABX:  bbb = 3'd7;
                    default: legal = 1'b0;
                endcase
                opcode = {aaa, bbb, 2'b01};
            end
            ASL, ROL, LSR, ROR, DEC, INC, STX, LDX, BIT, STY, LDY, CPY, CPX: begin
                case (mode)
                    MD_IMM:  begin bbb = 3'd0; legal = mnem inside {LDX, LDY, CPY, CPX}; end
                    MD_ZPG:  begin bbb = 3'd1; legal = 1'b1; end
                    MD_ACC:  begin bbb = 3'd2; legal = mnem inside {ASL, ROL, LSR, ROR}; end
                    MD_ABS:  begin bbb = 3'd3; legal = 1'b1; end
                    MD_ZPX:  begin bbb = 3'd5; legal = mnem inside {ASL, ROL, LSR, ROR, DEC, INC, STY, LDY}; end
                    MD_ZPY:  begin bbb = 3'd5; legal = mnem inside {STX, LDX}; end
                    MD_ABX:  begin bbb = 3'd7; legal = mnem inside {ASL, ROL, LSR, ROR, DEC, INC, LDY}; end
                    MD_ABY:  begin bbb = 3'd7; legal = (mnem == LDX); end
                    default: legal = 1'b0;
                endcase
                opcode = {aaa, bbb, cc};
            end
            JMP: begin
                legal  = (mode == MD_ABS) || (mode == MD_IND);
                opcode = (mode == MD_IND) ? 8'h6C : 8'h4C;
            end
            JSR: begin
                legal  = (mode == MD_ABS);
                opcode = 8'h20;
            end
            BPL, BMI, BVC, BVS, BCC, BCS, BNE, BEQ: begin
                legal  = (mode == MD_REL);
                opcode = fixed_op(mnem);
            end
            default: begin
                legal  = (mode == MD_IMP);
                opcode = fixed_op(mnem);
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - encodes one symbolic 6502 instruction into 1-3 byte writes at the location counter
// Optional ENC_ZP_PROMOTE_EN: absolute modes with a zero high byte are re-encoded as zero-page forms.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter logic [15:0] RESET_ORG = 16'h0000,
    parameter int          ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 org_load,
    input  logic [15:0]          org_addr,
    instr_encoder_if.slave       bus,
    output logic                 instr_done,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [15:0]          pc
);
    state_t      state, state_next;
    mnem_t       mnem_q;
    mode_t       mode_q;
    logic [15:0] operand_q;
    logic [7:0]  opcode_q, byte1_q, byte2_q;
    logic [1:0]  len_q;

    logic        map_legal;
    logic [7:0]  map_opcode;
    logic [1:0]  map_len;
    logic        promote;
    logic [7:0]  zp_opcode;
    logic [1:0]  zp_len;
    logic [15:0] rel_off;
    logic        rel_ok;
    logic        chk_legal;
    logic [7:0]  chk_opcode;
    logic [1:0]  chk_len;
    logic        accept;
    logic        wr_fire;
    logic        last_byte;

    instr_encoder_opcode_map u_map (
        .mnem   (mnem_q),
        .mode   (mode_q),
        .legal  (map_legal),
        .opcode (map_opcode),
        .len    (map_len)
    );

`ifdef ENC_ZP_PROMOTE_EN
    mode_t zp_mode;
    logic  zp_legal;

    always_comb begin
        case (mode_q)
            MD_ABS:  zp_mode = MD_ZPG;
            MD_ABX:  zp_mode = MD_ZPX;
            MD_ABY:  zp_mode = MD_ZPY;
            default: zp_mode = MD_IMP;
        endcase
    end

    instr_encoder_opcode_map u_zp_map (
        .mnem   (mnem_q),
        .mode   (zp_mode),
        .legal  (zp_legal),
        .opcode (zp_opcode),
        .len    (zp_len)
    );

    // Jumps always keep their 16-bit target form
    assign promote = zp_legal && (zp_mode != MD_IMP) && (operand_q[15:8] == 8'h00)
                     && !(mnem_q inside {JMP, JSR});
`else
    assign promote   = 1'b0;
    assign zp_opcode = 8'h00;
    assign zp_len    = LEN_2;
`endif

    // Branch offset is relative to the address after the 2-byte branch
    assign rel_off    = operand_q - (pc + 16'd2);
    assign rel_ok     = (rel_off[15:7] == 9'h000) || (rel_off[15:7] == 9'h1FF);
    assign chk_legal  = promote || (map_legal && ((mode_q != MD_REL) || rel_ok));
    assign chk_opcode = promote ? zp_opcode : map_opcode;
    assign chk_len    = promote ? zp_len : map_len;

    assign accept  = (state == S_IDLE) && (state_next == S_CHECK);
    assign wr_fire = bus.wr_valid && bus.wr_ready;

    always_comb begin
        state_next   = state;
        bus.in_ready = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_addr  = 16'h0000;
        bus.wr_data  = 8'h00;
        instr_done   = 1'b0;
        err          = 1'b0;
        last_byte    = 1'b0;
        case (state)
            S_IDLE: begin
                bus.in_ready = !org_load && !rst;
                if (bus.in_valid && !org_load && !rst) state_next = S_CHECK;
            end
            S_CHECK: begin
                if (chk_legal) begin
                    state_next = S_B0;
                end else begin
                    err        = 1'b1;
                    state_next = S_IDLE;
                end
            end
            S_B0, S_B1, S_B2: begin
                bus.wr_valid = 1'b1;
                bus.wr_addr  = pc;
                case (state)
                    S_B0:    begin bus.wr_data = opcode_q; last_byte = (len_q == LEN_1); end
                    S_B1:    begin bus.wr_data = byte1_q;  last_byte = (len_q == LEN_2); end
                    default: begin bus.wr_data = byte2_q;  last_byte = 1'b1; end
                endcase
                if (bus.wr_ready) begin
                    if (last_byte) begin
                        instr_done = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        state_next = (state == S_B0) ? S_B1 : S_B2;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            pc      <= RESET_ORG;
            err_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == S_IDLE && org_load) pc <= org_addr;
            else if (wr_fire)                pc <= pc + 16'd1;
            if (err && !(&err_cnt))          err_cnt <= err_cnt + ERR_CNT_W'(1);
        end
    end

    // Instruction fields and resolved bytes; only read in states they were written for
    always_ff @(posedge clk) begin
        if (accept) begin
            mnem_q    <= bus.in_mnem;
            mode_q    <= bus.in_mode;
            operand_q <= bus.in_operand;
        end
        if (state == S_CHECK) begin
            opcode_q <= chk_opcode;
            byte1_q  <= (mode_q == MD_REL) ? rel_off[7:0] : operand_q[7:0];
            byte2_q  <= operand_q[15:8];
            len_q    <= chk_len;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - directed self-checking bench for instr_encoder
module tb_instr_encoder;
    import instr_encoder_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        org_load;
    logic [15:0] org_addr;
    logic        instr_done;
    logic        err;
    logic [7:0]  err_cnt;
    logic [15:0] pc;

    instr_encoder_if bus();

    instr_encoder #(.RESET_ORG(16'h0000), .ERR_CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .org_load   (org_load),
        .org_addr   (org_addr),
        .bus        (bus),
        .instr_done (instr_done),
        .err        (err),
        .err_cnt    (err_cnt),
        .pc         (pc)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          acc_cyc = 0;
    logic [23:0] wr_q[$];
    int          wr_cyc_q[$];
    logic [23:0] exp_q[$];
    int          done_cnt   = 0;
    int          err_pulses = 0;
    int          stab_bad   = 0;
    logic        saw_wr     = 1'b0;
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic [23:0] prev_word  = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Byte-write monitor: each record is {addr, data} of a write that lands on the next edge
    always @(negedge clk) begin
        if (bus.wr_valid) saw_wr = 1'b1;
        if (bus.wr_valid && bus.wr_ready) begin
            wr_q.push_back({bus.wr_addr, bus.wr_data});
            wr_cyc_q.push_back(cyc);
        end
        if (instr_done) done_cnt++;
        if (err) err_pulses++;
        if (prev_valid && !prev_ready &&
            (!bus.wr_valid || ({bus.wr_addr, bus.wr_data} != prev_word))) stab_bad++;
        prev_valid = bus.wr_valid;
        prev_ready = bus.wr_ready;
        prev_word  = {bus.wr_addr, bus.wr_data};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_log();
        wr_q.delete();
        wr_cyc_q.delete();
        exp_q.delete();
        done_cnt   = 0;
        err_pulses = 0;
        stab_bad   = 0;
        saw_wr     = 1'b0;
    endtask

    task automatic set_org(input logic [15:0] a);
        org_load = 1'b1;
        org_addr = a;
        #1;
        check("org_blocks_in_ready", {31'd0, bus.in_ready}, 32'd0);
        step(1);
        org_load = 1'b0;
    endtask

    task automatic issue(input mnem_t m, input mode_t md, input logic [15:0] op);
        int   guard;
        logic hit;
        guard = 0;
        hit   = 1'b0;
        bus.in_valid   = 1'b1;
        bus.in_mnem    = m;
        bus.in_mode    = md;
        bus.in_operand = op;
        do begin
            @(negedge clk);
            acc_cyc = cyc;
            hit     = bus.in_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!hit && guard < 20);
        bus.in_valid = 1'b0;
        check("accept", {31'd0, hit}, 32'd1);
    endtask

    task automatic compare_log(input string tag);
        check({tag, "_count"}, wr_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), {8'd0, wr_q[i]}, {8'd0, exp_q[i]});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        rst            = 1'b1;
        org_load       = 1'b0;
        org_addr       = 16'h0000;
        bus.in_valid   = 1'b0;
        bus.in_mnem    = NOP;
        bus.in_mode    = MD_IMP;
        bus.in_operand = 16'h0000;
        bus.wr_ready   = 1'b1;
        step(2);
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("rst_wr_valid", {31'd0, bus.wr_valid}, 32'd0);
        check("rst_pc", {16'd0, pc}, 32'h0000);
        check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
        rst = 1'b0;
        #1;
        check("idle_in_ready", {31'd0, bus.in_ready}, 32'd1);
        step(1);

        clear_log(); set_org(16'h0200); issue(LDA, MD_IMM, 16'h0042); step(6);
        exp_q = '{24'h0200A9, 24'h020142}; compare_log("lda_imm");
        check("lda_imm_done", done_cnt, 1);
        check("lda_imm_pc", {16'd0, pc}, 32'h0202);

        clear_log(); issue(NOP, MD_IMP, 16'hFFFF); step(4);
        exp_q = '{24'h0202EA}; compare_log("nop");
        if (wr_cyc_q.size() > 0) check("nop_latency", wr_cyc_q[0] - acc_cyc, 2);

        clear_log(); issue(ASL, MD_ACC, 16'h0000); step(4);
        exp_q = '{24'h02030A}; compare_log("asl_acc");

        clear_log(); set_org(16'h0210); issue(BNE, MD_REL, 16'h0200); step(6);
        exp_q = '{24'h0210D0, 24'h0211EE}; compare_log("bne_back");
        check("bne_back_pc", {16'd0, pc}, 32'h0212);

        clear_log(); set_org(16'h0210); issue(BNE, MD_REL, 16'h0291); step(6);
        exp_q = '{24'h0210D0, 24'h02117F}; compare_log("bne_p127");

        clear_log(); set_org(16'h0210); issue(BEQ, MD_REL, 16'h0192); step(6);
        exp_q = '{24'h0210F0, 24'h021180}; compare_log("beq_m128");

        clear_log(); set_org(16'h0210); issue(BNE, MD_REL, 16'h0300); step(4);
        check("bne_far_err", err_pulses, 1);
        check("bne_far_err_cnt", {24'd0, err_cnt}, 32'd1);
        check("bne_far_no_wr", {31'd0, saw_wr}, 32'd0);
        check("bne_far_pc", {16'd0, pc}, 32'h0210);

        issue(BNE, MD_REL, 16'h0292); step(1);
        check("bne_p128_err_cnt", {24'd0, err_cnt}, 32'd2);
        issue(STA, MD_IMM, 16'h0011); step(1);
        check("sta_imm_err_cnt", {24'd0, err_cnt}, 32'd3);
        issue(JMP, MD_ZPG, 16'h0011); step(1);
        check("jmp_zpg_err_cnt", {24'd0, err_cnt}, 32'd4);
        for (int i = 0; i < 296; i++) begin
            issue(STA, MD_IMM, 16'h0000);
            step(1);
        end
        check("err_cnt_saturate", {24'd0, err_cnt}, 32'd255);
        check("err_pulses_300", err_pulses, 300);
        check("illegal_no_wr", {31'd0, saw_wr}, 32'd0);

        clear_log(); set_org(16'hFFFF); issue(JMP, MD_IND, 16'h1234); step(7);
        exp_q = '{24'hFFFF6C, 24'h000034, 24'h000112}; compare_log("jmp_ind_wrap");
        check("jmp_ind_wrap_pc", {16'd0, pc}, 32'h0002);

        clear_log(); set_org(16'h0400);
        bus.wr_ready = 1'b0;
        fork
            issue(JSR, MD_ABS, 16'hC000);
            repeat (20) begin
                step(1);
                bus.wr_ready = ~bus.wr_ready;
            end
        join
        bus.wr_ready = 1'b1;
        step(3);
        exp_q = '{24'h040020, 24'h040100, 24'h0402C0}; compare_log("jsr_toggle");
        check("jsr_toggle_stable", stab_bad, 0);
        check("jsr_toggle_done", done_cnt, 1);
        check("jsr_toggle_pc", {16'd0, pc}, 32'h0403);

        clear_log(); set_org(16'h0500); issue(LDA, MD_ABS, 16'h0010); step(7);
`ifdef ENC_ZP_PROMOTE_EN
        exp_q = '{24'h0500A5, 24'h050110}; compare_log("lda_abs_zp");
        check("lda_abs_zp_pc", {16'd0, pc}, 32'h0502);
`else
        exp_q = '{24'h0500AD, 24'h050110, 24'h050200}; compare_log("lda_abs_zp");
        check("lda_abs_zp_pc", {16'd0, pc}, 32'h0503);
`endif

        clear_log(); set_org(16'h0600); issue(LDA, MD_ABY, 16'h0010); step(7);
        exp_q = '{24'h0600B9, 24'h060110, 24'h060200}; compare_log("lda_aby_zp");

        clear_log(); set_org(16'h0700); issue(JMP, MD_ABS, 16'h0010); step(7);
        exp_q = '{24'h07004C, 24'h070110, 24'h070200}; compare_log("jmp_abs_zp");

        clear_log(); set_org(16'h0800); issue(LDX, MD_ZPY, 16'hAB80); step(6);
        exp_q = '{24'h0800B6, 24'h080180}; compare_log("ldx_zpy");

        clear_log(); set_org(16'h0880); issue(INC, MD_ABX, 16'h1234); step(7);
        exp_q = '{24'h0880FE, 24'h088134, 24'h088212}; compare_log("inc_abx");

        clear_log(); set_org(16'h0900);
        bus.wr_ready = 1'b0;
        issue(LDA, MD_ABS, 16'h1234);
        step(1);
        check("b0_addr", {16'd0, bus.wr_addr}, 32'h0900);
        bus.wr_ready = 1'b1;
        step(1);
        bus.wr_ready = 1'b0;
        #1;
        check("b1_addr", {16'd0, bus.wr_addr}, 32'h0901);
        check("b1_data", {24'd0, bus.wr_data}, 32'h34);
        rst = 1'b1;
        step(1);
        check("abort_wr_valid", {31'd0, bus.wr_valid}, 32'd0);
        check("abort_pc", {16'd0, pc}, 32'h0000);
        check("abort_err_cnt", {24'd0, err_cnt}, 32'd0);
        exp_q = '{24'h0900AD}; compare_log("abort_partial");
        rst = 1'b0;
        bus.wr_ready = 1'b1;
        #1;
        check("abort_idle", {31'd0, bus.in_ready}, 32'd1);
        step(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
